// File: rtl/contador_vga.sv
// VGA raster timing generator: pixel-enable divider plus pixel/line counters with
// registered horizontal sync and blanking aligned to the current pixel column.
module contador_vga #(
  parameter int DIV       = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_TOTAL   = 525
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       habilitar,
  output logic       pixel_tick,
  output logic [9:0] pixel_num,
  output logic [9:0] linea_num,
  output logic       hsync,
  output logic       n_blank_h,
  output logic       fin_linea,
  output logic       fin_cuadro
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [9:0]       PX_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       LN_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       VIS_LAST   = 10'(H_VISIBLE - 1);
  localparam logic [9:0]       SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]       SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       pixel_next;
  logic [9:0]       linea_next;
  logic             line_wrap;

  // Gated by n_rst so the tick stays low while reset is held, even at DIV=1.
  assign pixel_tick = habilitar & n_rst & (div_cnt == DIV_LAST);
  assign line_wrap  = (pixel_num >= PX_LAST);
  assign fin_linea  = pixel_tick & (pixel_num == PX_LAST);
  assign fin_cuadro = fin_linea & (linea_num == LN_LAST);

  // Out-of-range counts fall back to 0 on the next tick.
  always_comb begin
    pixel_next = line_wrap ? 10'd0 : pixel_num + 10'd1;
    linea_next = linea_num;
    if (linea_num > LN_LAST) begin
      linea_next = 10'd0;
    end else if (line_wrap) begin
      linea_next = (linea_num == LN_LAST) ? 10'd0 : linea_num + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt <= '0;
    end else if (habilitar) begin
      div_cnt <= (div_cnt >= DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Sync/blank decode the next column so they change on the same edge as pixel_num.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pixel_num <= 10'd0;
      linea_num <= 10'd0;
      hsync     <= 1'b1;
      n_blank_h <= 1'b1;
    end else if (pixel_tick) begin
      pixel_num <= pixel_next;
      linea_num <= linea_next;
      hsync     <= !((pixel_next >= SYNC_FIRST) && (pixel_next <= SYNC_LAST));
      n_blank_h <= (pixel_next <= VIS_LAST);
    end
  end

endmodule

// File: tb/tb_contador_vga.sv
// Bench for contador_vga: checkpoint table, corner-case sequences and randomized
// enable/reset traffic scored against an arithmetic raster model.
module tb_contador_vga;

  logic clk = 1'b0;
  logic n_rst;
  logic habilitar;

  always #5 clk = ~clk;

  logic       tick2, hs2, nb2, fl2, fc2;
  logic [9:0] px2, ln2;
  logic       tick1, hs1, nb1, fl1, fc1;
  logic [9:0] px1, ln1;
  logic       tick_s, hs_s, nb_s, fl_s, fc_s;
  logic [9:0] px_s, ln_s;

  contador_vga u_div2 (
    .clk(clk), .n_rst(n_rst), .habilitar(habilitar), .pixel_tick(tick2),
    .pixel_num(px2), .linea_num(ln2), .hsync(hs2), .n_blank_h(nb2),
    .fin_linea(fl2), .fin_cuadro(fc2));

  contador_vga #(.DIV(1)) u_div1 (
    .clk(clk), .n_rst(n_rst), .habilitar(habilitar), .pixel_tick(tick1),
    .pixel_num(px1), .linea_num(ln1), .hsync(hs1), .n_blank_h(nb1),
    .fin_linea(fl1), .fin_cuadro(fc1));

  // Shrunken raster (15 columns x 4 lines) so whole frames fit in a short run.
  contador_vga #(.DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_TOTAL(4)) u_small (
    .clk(clk), .n_rst(n_rst), .habilitar(habilitar), .pixel_tick(tick_s),
    .pixel_num(px_s), .linea_num(ln_s), .hsync(hs_s), .n_blank_h(nb_s),
    .fin_linea(fl_s), .fin_cuadro(fc_s));

  typedef struct packed {
    logic       tick;
    logic [9:0] px;
    logic [9:0] ln;
    logic       hs;
    logic       nb;
    logic       fl;
    logic       fc;
  } vga_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Raster position follows from the number of enabled clocks since reset.
  int e_cnt;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) e_cnt <= 0;
    else if (habilitar) e_cnt <= e_cnt + 1;
  end

  function automatic vga_t ref_model(input int e, input int div, input int hv, input int hf,
                                     input int hsw, input int hb, input int vt,
                                     input logic en, input logic rst_ok);
    vga_t r;
    int ht, t, px, ln;
    ht = hv + hf + hsw + hb;
    t  = e / div;
    px = t % ht;
    ln = (t / ht) % vt;
    r.tick = en && rst_ok && ((e % div) == div - 1);
    r.px   = 10'(px);
    r.ln   = 10'(ln);
    r.hs   = !((px >= hv + hf) && (px < hv + hf + hsw));
    r.nb   = (px < hv);
    r.fl   = r.tick && (px == ht - 1);
    r.fc   = r.fl && (ln == vt - 1);
    return r;
  endfunction

  always @(negedge clk) begin
    #2;
    check("sb_div2", 32'({tick2, px2, ln2, hs2, nb2, fl2, fc2}),
          32'(ref_model(e_cnt, 2, 640, 16, 96, 48, 525, habilitar, n_rst)));
    check("sb_div1", 32'({tick1, px1, ln1, hs1, nb1, fl1, fc1}),
          32'(ref_model(e_cnt, 1, 640, 16, 96, 48, 525, habilitar, n_rst)));
    check("sb_small", 32'({tick_s, px_s, ln_s, hs_s, nb_s, fl_s, fc_s}),
          32'(ref_model(e_cnt, 2, 8, 2, 3, 2, 4, habilitar, n_rst)));
  end

  typedef struct {
    logic hab;
    int   ncyc;
    int   px;
    int   ln;
    logic tick;
    logic hs;
    logic nb;
    logic fl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int  cnt;
    int  fl1_at, fc_s_at;
    bit  hold_ok;

    vecs[0]  = '{1'b1, 0,    0,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1,    0,   0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1,    1,   0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1277, 639, 0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1,    640, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 31,   655, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1,    656, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 191,  751, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1,    752, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 50,   752, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 95,   799, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1,    0,   1, 1'b0, 1'b1, 1'b1, 1'b0};

    n_rst = 1'b0;
    habilitar = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_tick2", 32'(tick2), 32'd0);
    check("rst_tick1", 32'(tick1), 32'd0);
    check("rst_px",    32'(px2),   32'd0);
    check("rst_ln",    32'(ln2),   32'd0);
    check("rst_hsync", 32'(hs2),   32'd1);
    check("rst_nblank", 32'(nb2),  32'd1);
    check("rst_fins",  32'({fl2, fc2, fl1, fc1}), 32'd0);

    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      habilitar = vecs[i].hab;
      repeat (vecs[i].ncyc) @(negedge clk);
      #1;
      check($sformatf("vec%0d_px", i),   32'(px2),   32'(vecs[i].px));
      check($sformatf("vec%0d_ln", i),   32'(ln2),   32'(vecs[i].ln));
      check($sformatf("vec%0d_tick", i), 32'(tick2), 32'(vecs[i].tick));
      check($sformatf("vec%0d_hs", i),   32'(hs2),   32'(vecs[i].hs));
      check($sformatf("vec%0d_nb", i),   32'(nb2),   32'(vecs[i].nb));
      check($sformatf("vec%0d_fl", i),   32'(fl2),   32'(vecs[i].fl));
    end

    // Enable hold at column 300.
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    habilitar = 1'b1;
    for (int i = 0; i < 1000 && px2 != 10'd300; i++) @(negedge clk);
    check("hold_reach300", 32'(px2), 32'd300);
    habilitar = 1'b0;
    hold_ok = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (px2 != 10'd300 || tick2 || hs2 != 1'b1 || nb2 != 1'b1 || fl2) hold_ok = 1'b0;
    end
    check("hold_frozen", 32'(hold_ok), 32'd1);
    habilitar = 1'b1;
    @(negedge clk);
    check("hold_edge1", 32'(px2), 32'd300);
    @(negedge clk);
    check("hold_edge2", 32'(px2), 32'd301);

    // Asynchronous reset inside the sync window.
    for (int i = 0; i < 2000 && px2 != 10'd700; i++) @(negedge clk);
    check("midrst_px700", 32'(px2), 32'd700);
    check("midrst_insync", 32'(hs2), 32'd0);
    #3;
    n_rst = 1'b0;
    #1;
    check("midrst_px", 32'(px2), 32'd0);
    check("midrst_ln", 32'(ln2), 32'd0);
    check("midrst_hsync", 32'(hs2), 32'd1);
    check("midrst_nblank", 32'(nb2), 32'd1);

    // Frame wrap on the small raster and line length at DIV=1.
    @(negedge clk);
    n_rst = 1'b1;
    cnt = 0;
    fl1_at = -1;
    fc_s_at = -1;
    while (cnt < 1000 && (fl1_at < 0 || fc_s_at < 0)) begin
      if (fl1 && fl1_at < 0) fl1_at = cnt;
      if (fc_s && fc_s_at < 0) begin
        fc_s_at = cnt;
        check("frame_last_px", 32'(px_s), 32'd14);
        check("frame_last_ln", 32'(ln_s), 32'd3);
        @(negedge clk);
        cnt++;
        check("frame_wrap_px", 32'({px_s, ln_s}), 32'd0);
        check("frame_fc_pulse", 32'(fc_s), 32'd0);
        continue;
      end
      @(negedge clk);
      cnt++;
    end
    check("frame_clks", 32'(fc_s_at + 1), 32'd120);
    check("div1_line_clks", 32'(fl1_at + 1), 32'd800);

    // Randomized enable and reset traffic.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      habilitar = ($urandom_range(0, 9) != 0);
      n_rst = ($urandom_range(0, 799) != 0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
